hack_rom_loader: RTL
====================

# hack_rom_loader

Byte-stream program loader sitting directly upstream of the Hack `top` (CPU + instruction ROM + data RAM). It receives a framed Hack binary over a valid/ready byte interface, assembles big-endian 16-bit instruction words, writes them into the instruction ROM, and holds the CPU in reset until a complete, checksum-verified image is in place. The only way to reload is an explicit re-arm request.

## Interface
Parameters:
- `ADDR_W`, 15: ROM address width. Capacity is 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte.
- `load_req`  in  1  re-arm request; honoured only in DONE or ERR.
- `rom_we`  out  1  ROM write strobe, one-cycle pulse.
- `rom_addr`  out  ADDR_W  ROM write address.
- `rom_wdata`  out  16  ROM write data.
- `cpu_reset`  out  1  active-high reset to `top`.
- `done`  out  1  image loaded and verified.
- `err`  out  1  framing or checksum error.
- `word_count`  out  16  number of words written in the current load.

## Operation
- Frame format: `N_hi`, `N_lo` (word count, big-endian), then N words sent high byte first, then one checksum byte.
- Checksum = 8-bit sum mod 256 of all payload bytes. Header bytes are excluded.
- States: HDR_HI -> HDR_LO -> (DAT_HI <-> DAT_LO)* -> CHK -> DONE | ERR.
- HDR_LO accept:
  - N > 2^ADDR_W -> ERR.
  - N == 0 -> CHK.
  - Otherwise -> DAT_HI.
- DAT_HI accept: latch the high byte.
- DAT_LO accept:
  - Issue a ROM write of {hi, lo} at address `word_count`.
  - `word_count` increments.
  - -> CHK when `word_count + 1 == N`, else DAT_HI.
- CHK accept: byte equals running sum -> DONE, otherwise -> ERR.
- DONE and ERR: `in_ready` = 0; input bytes are ignored.
- `load_req` high at an edge in DONE or ERR:
  - -> HDR_HI.
  - Clears `done`, `err`, `word_count` and the checksum accumulator.
  - Sets `cpu_reset` = 1.
  - `load_req` is ignored in all other states.
- ROM contents beyond N are not cleared.

## Timing
- Reset values (edge with `rst_n` = 0):
  - State = HDR_HI.
  - `in_ready` = 1 (from the next cycle onward), `cpu_reset` = 1.
  - `done` = 0, `err` = 0, `rom_we` = 0, `rom_addr` = 0, `rom_wdata` = 0.
  - `word_count` = 0, checksum accumulator = 0.
- Reset mid-frame: discard all partial state and apply the reset values above; the next accepted byte is `N_hi`.
- Handshake:
  - A byte transfers on an edge where `in_valid` & `in_ready` are both 1.
  - `in_ready` is a function of state only (1 in HDR_HI..CHK) and never depends on `in_valid`.
  - Gaps on `in_valid` are allowed at any point.
- ROM write:
  - `rom_we`, `rom_addr` and `rom_wdata` are registered and valid in the cycle immediately after the edge that accepts the low byte.
  - `rom_we` is high for exactly 1 cycle.
  - Back-to-back bytes (one per cycle) are sustained with no stall.
- `cpu_reset`, `done` and `err` are registered and change on the edge that accepts the checksum byte (or `N_lo` for an oversize error).
- `word_count` updates on the same edge as the write is registered.
- `load_req` and a byte arriving on the same edge in DONE: the re-arm wins and the byte is not consumed, since `in_ready` was 0.

## Test plan
- Good image, bytes 00 02 00 10 E3 08 FB sent back-to-back -> `rom_we` pulses twice: addr 0 = 0x0010, addr 1 = 0xE308. Then `done` = 1, `cpu_reset` = 0, `word_count` = 2, `err` = 0.
- Same image with checksum byte 0x00 -> both ROM writes occur; then `err` = 1, `done` = 0, `cpu_reset` stays 1, `in_ready` = 0.
- Header 90 00 (N = 36864 > 32768) -> `err` = 1 on the edge accepting 0x00; no `rom_we` pulses.
- Image 00 01 12 34 46 with random 0-3 cycle gaps on `in_valid` -> a single write of 0x1234 at addr 0, then `done` = 1. N = 0 image 00 00 00 -> `done` = 1, no writes.
- `rst_n` low for 1 cycle after the 3rd payload byte, then a full good image -> reset values observed, no stale write, and a correct load completes.
- After DONE, pulse `load_req`, then load 00 01 FF FF FE -> `cpu_reset` returns to 1 on the `load_req` edge and `done` clears. The write is addr 0 = 0xFFFF, then `done` = 1 and `cpu_reset` = 0.

Source files
------------

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - framed byte-stream loader for the Hack instruction ROM
// Holds the CPU in reset until a complete, checksum-verified image has been written.
module hack_rom_loader #(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              load_req,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count
);

   typedef enum logic [2:0] {
      S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_DONE, S_ERR
   } state_t;

   // Largest legal word count is the full ROM capacity.
   localparam logic [16:0] CAP = 17'(1) << ADDR_W;

   state_t              state_q, state_d;
   logic [7:0]          hi_q, hi_d;
   logic [7:0]          sum_q, sum_d;
   logic [15:0]         n_q, n_d;
   logic [15:0]         wc_q, wc_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_HDR_HI;
         hi_q        <= 8'd0;
         sum_q       <= 8'd0;
         n_q         <= 16'd0;
         wc_q        <= 16'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'd0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         sum_q       <= sum_d;
         n_q         <= n_d;
         wc_q        <= wc_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      sum_d       = sum_q;
      n_d         = n_q;
      wc_d        = wc_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      err_d       = err_q;
      in_ready    = (state_q != S_DONE) && (state_q != S_ERR);
      accept      = in_valid && in_ready;

      case (state_q)
         S_HDR_HI: if (accept) begin
            hi_d    = in_data;
            state_d = S_HDR_LO;
         end
         S_HDR_LO: if (accept) begin
            n_d = {hi_q, in_data};
            if ({1'b0, hi_q, in_data} > CAP) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if ({hi_q, in_data} == 16'd0) begin
               state_d = S_CHK;
            end else begin
               state_d = S_DAT_HI;
            end
         end
         S_DAT_HI: if (accept) begin
            hi_d    = in_data;
            sum_d   = sum_q + in_data;
            state_d = S_DAT_LO;
         end
         S_DAT_LO: if (accept) begin
            we_d    = 1'b1;
            addr_d  = wc_q[ADDR_W-1:0];
            wdata_d = {hi_q, in_data};
            sum_d   = sum_q + in_data;
            wc_d    = wc_q + 16'd1;
            state_d = (wc_q + 16'd1 == n_q) ? S_CHK : S_DAT_HI;
         end
         S_CHK: if (accept) begin
            if (in_data == sum_q) begin
               done_d      = 1'b1;
               cpu_reset_d = 1'b0;
               state_d     = S_DONE;
            end else begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         S_DONE, S_ERR: if (load_req) begin
            state_d     = S_HDR_HI;
            done_d      = 1'b0;
            err_d       = 1'b0;
            wc_d        = 16'd0;
            sum_d       = 8'd0;
            cpu_reset_d = 1'b1;
         end
         default: state_d = S_HDR_HI;
      endcase
   end

   assign rom_we     = we_q;
   assign rom_addr   = addr_q;
   assign rom_wdata  = wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = wc_q;

endmodule
